count_event_mon: RTL and testbench

- Downstream monitor stage for the free-running `counter` block.
- Samples the counter's `q` every clock and detects three events:
  - wrap-around;
  - rising crossing of a programmable threshold;
  - stall, where `q` is held constant.
- Each event is queued as a record in a small first-word-fall-through FIFO, drained over a valid/ready interface.
- Used in the picorv32 sim/eda flow to turn raw counter activity into checkable event streams, without polling `q` in the bench.

---
 rtl/count_event_mon.sv | 166 ++++++++++++++++
 tb/tb_count_event_mon.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_mon.sv
// Event monitor for a free-running counter: detects wrap, threshold crossing and (optionally) stall,
// queueing {code, value} records in a FWFT FIFO. Define COUNT_EVENT_MON_STALL_EN for stall detection.
module count_event_mon #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] thresh,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [WIDTH-1:0] evt_value,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        CodeWrap   = 2'd0,
        CodeThresh = 2'd1,
        CodeStall  = 2'd2
    } code_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (STALL_CYCLES < 2) begin : g_bad_stall
        $error("STALL_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0] q_prev;
    logic             primed;
    logic             evt_wrap;
    logic             evt_thresh;
    logic             evt_stall;
    logic             evt_det;
    code_e            evt_code_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_prev <= '0;
            primed <= 1'b0;
        end else begin
            q_prev <= q;
            primed <= 1'b1;
        end
    end

    // Wrap needs q < q_prev, a crossing needs q > q_prev, a stall needs q == q_prev,
    // so at most one of these is ever true in a cycle.
    assign evt_wrap   = primed && (q < q_prev);
    assign evt_thresh = primed && (q_prev < thresh) && (q >= thresh);

`ifdef COUNT_EVENT_MON_STALL_EN
    localparam int unsigned StallW = $clog2(STALL_CYCLES + 1);
    localparam logic [StallW-1:0] StallFire = StallW'(STALL_CYCLES - 1);
    localparam logic [StallW-1:0] StallSat  = StallW'(STALL_CYCLES);

    logic [StallW-1:0] stall_cnt;
    logic [StallW-1:0] stall_cnt_d;

    // Counter saturates one past the firing value so a long hold fires only once.
    always_comb begin
        stall_cnt_d = stall_cnt;
        evt_stall   = 1'b0;
        if (!primed || q != q_prev) begin
            stall_cnt_d = '0;
        end else begin
            evt_stall = (stall_cnt == StallFire);
            if (stall_cnt != StallSat) begin
                stall_cnt_d = stall_cnt + StallW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt_d;
        end
    end
`else
    assign evt_stall = 1'b0;
`endif

    assign evt_det = evt_wrap | evt_thresh | evt_stall;

    always_comb begin
        if (evt_wrap) begin
            evt_code_new = CodeWrap;
        end else if (evt_thresh) begin
            evt_code_new = CodeThresh;
        end else begin
            evt_code_new = CodeStall;
        end
    end

    logic [WIDTH+1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH+1:0] head;

    assign full = (count_q == FullCnt);
    assign pop  = evt_valid & evt_ready;
    assign push = evt_det & (~full | pop);
    assign drop = evt_det & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
        // A drop coinciding with a clear keeps the flag set.
        ovf_d = drop | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {evt_code_new, q};
        end
    end

    // Head is gated so stale storage never shows through while empty.
    assign head      = mem[rd_ptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? head[WIDTH+1:WIDTH] : 2'd0;
    assign evt_value = evt_valid ? head[WIDTH-1:0] : '0;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_count_event_mon.sv
// Scoreboard bench for count_event_mon: directed stimulus pushes expected records, a negedge
// monitor pops and compares every accepted record.
module tb_count_event_mon;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STALL_CYCLES = 16;
`ifdef COUNT_EVENT_MON_STALL_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] q = '0;
    logic [WIDTH-1:0] thresh = '0;
    logic             evt_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             evt_valid;
    logic [1:0]       evt_code;
    logic [WIDTH-1:0] evt_value;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] mon_e;

    count_event_mon #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q(q),
        .thresh(thresh),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_value(evt_value),
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_rec(input logic [1:0] c, input logic [WIDTH-1:0] v);
        exp_q.push_back({c, v});
    endtask

    task automatic step(input logic [WIDTH-1:0] v);
        q = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Raises thresh just ahead of q so each step is a rising crossing with no wrap in between.
    task automatic crossings(input int n, input int keep);
        for (int j = 0; j < n; j++) begin
            thresh = 8'(20 + 10 * j);
            if (j < keep) expect_rec(2'd1, 8'(20 + 10 * j));
            step(8'(20 + 10 * j));
        end
    endtask

    // Monitor: every accepted record must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got code %0d value %0d, expected none",
                         evt_code, evt_value);
            end else begin
                mon_e = exp_q.pop_front();
                check("record_code", int'(evt_code), int'(mon_e[WIDTH+1:WIDTH]));
                check("record_value", int'(evt_value), int'(mon_e[WIDTH-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_code", int'(evt_code), 0);
        check("rst_evt_value", int'(evt_value), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;

        // Wrap: thresh = 0 can never be crossed, so only the 255->0 step reports
        thresh = '0;
        for (int i = 0; i < 300; i++) begin
            if (i == 256) expect_rec(2'd0, 8'd0);
            step(8'(i));
        end
        step(8'd44);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Threshold crossing and its one-cycle latency
        thresh = 8'd50;
        q = '0;
        do_reset();
        for (int v = 0; v <= 60; v++) begin
            if (v == 50) expect_rec(2'd1, 8'd50);
            step(8'(v));
            if (v == 49) begin
                @(negedge clk);
                check("thr_valid_before", int'(evt_valid), 0);
            end
            if (v == 50) begin
                @(negedge clk);
                check("thr_valid_after", int'(evt_valid), 1);
                check("thr_code_after", int'(evt_code), 1);
                check("thr_value_after", int'(evt_value), 50);
            end
        end
        step(8'd61);
        check("thr_queue_empty", exp_q.size(), 0);

        // Stall: q held at 7; the 16th equal compare is the 17th sample
        thresh = '0;
        q = 8'd7;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            if (k == 17 && StallEn) expect_rec(2'd2, 8'd7);
            step(8'd7);
            if (k == 16) begin
                @(negedge clk);
                check("stall_valid_15th", int'(evt_valid), 0);
            end
            if (k == 17) begin
                @(negedge clk);
                check("stall_valid_16th", int'(evt_valid), StallEn ? 1 : 0);
            end
        end
        step(8'd8);
        step(8'd9);
        check("stall_queue_empty", exp_q.size(), 0);

        // Overflow: 5 crossings into a 4-deep FIFO with no consumer
        evt_ready = 1'b0;
        q = '0;
        thresh = 8'd20;
        do_reset();
        step(8'd10);
        crossings(4, 4);
        @(negedge clk);
        check("ovf_before_drop", int'(overflow), 0);
        thresh = 8'd60;
        step(8'd60);
        @(negedge clk);
        check("ovf_after_drop", int'(overflow), 1);
        check("ovf_head_kept", int'(evt_value), 20);
        evt_ready = 1'b1;
        for (int v = 61; v <= 66; v++) step(8'(v));
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_valid_drained", int'(evt_valid), 0);
        check("ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        step(8'd67);
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", int'(overflow), 0);

        // Full FIFO: push and pop in the same cycle
        evt_ready = 1'b0;
        q = '0;
        thresh = 8'd20;
        do_reset();
        step(8'd10);
        crossings(4, 4);
        thresh = 8'd60;
        evt_ready = 1'b1;
        expect_rec(2'd1, 8'd60);
        step(8'd60);
        evt_ready = 1'b0;
        @(negedge clk);
        check("full_pp_overflow", int'(overflow), 0);
        check("full_pp_head", int'(evt_value), 30);
        // Still full: one more crossing must be dropped
        thresh = 8'd70;
        step(8'd70);
        @(negedge clk);
        check("full_pp_still_full", int'(overflow), 1);
        evt_ready = 1'b1;
        for (int v = 71; v <= 76; v++) step(8'(v));
        check("full_pp_drained", exp_q.size(), 0);

        // Reset mid-operation with records queued and overflow set
        evt_ready = 1'b0;
        q = '0;
        thresh = 8'd20;
        do_reset();
        step(8'd10);
        crossings(5, 4);
        step(8'd200);
        @(negedge clk);
        check("mid_pre_overflow", int'(overflow), 1);
        q = '0;
        do_reset();
        @(negedge clk);
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_code", int'(evt_code), 0);
        check("mid_rst_value", int'(evt_value), 0);
        exp_q.delete();
        evt_ready = 1'b1;
        step(8'd0);
        step(8'd1);
        step(8'd2);
        @(negedge clk);
        check("mid_no_wrap_valid", int'(evt_valid), 0);
        check("mid_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
